// File: rtl/lut7_cfg_sched_if.sv
// rtl/lut7_cfg_sched_if.sv - config stream, lookup request and response bundle for lut7_cfg_sched
interface lut7_cfg_sched_if #(
    parameter int N     = 7,
    parameter int CFG_W = 8
);
    logic             cfg_start;
    logic             cfg_valid;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_done;
    logic             configured;
    logic             req_valid;
    logic [N-1:0]     req_addr;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_data;
    logic             rsp_ready;

    modport master (
        output cfg_start, cfg_valid, cfg_data, req_valid, req_addr, rsp_ready,
        input  cfg_ready, cfg_done, configured, req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, req_valid, req_addr, rsp_ready,
        output cfg_ready, cfg_done, configured, req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/lut7_cfg_sched.sv
// rtl/lut7_cfg_sched.sv - runtime-loadable 7-input LUT with beat loader and 2-stage lookup pipeline
module lut7_cfg_sched #(
    parameter int N     = 7,
    parameter int CFG_W = 8
) (
    input logic              CLK,
    input logic              RESETN,
    lut7_cfg_sched_if.slave  bus
);
    localparam int DEPTH  = 2 ** N;
    localparam int BEATS  = DEPTH / CFG_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int LEAVES = DEPTH / 16;
    localparam int SEL_W  = N - 4;

    typedef enum logic [1:0] {UNCFG, LOAD, DRAIN, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DEPTH-1:0]   tbl_q;
    logic               cfg_done_q;
    logic               s1_v_q;
    logic [LEAVES-1:0]  s1_leaf_q;
    logic [SEL_W-1:0]   s1_sel_q;
    logic               s2_v_q;
    logic               s2_data_q;

    logic               cfg_xfer;
    logic               last_beat;
    logic               s2_free;
    logic               s1_free;
    logic               req_fire;
    logic [LEAVES-1:0]  leaf_d;
    logic               tree_out;

    // A restart request in LOAD takes priority over a beat offered in the same cycle.
    assign bus.cfg_ready  = (state_q == LOAD) & ~bus.cfg_start;
    assign cfg_xfer       = bus.cfg_valid & bus.cfg_ready;
    assign last_beat      = cfg_xfer & (cnt_q == CNT_W'(BEATS - 1));
    assign s2_free        = ~s2_v_q | bus.rsp_ready;
    assign s1_free        = ~s1_v_q | s2_free;
    assign bus.req_ready  = (state_q == RUN) & ~bus.cfg_start & s1_free;
    assign req_fire       = bus.req_valid & bus.req_ready;
    assign bus.configured = (state_q == RUN);
    assign bus.cfg_done   = cfg_done_q;
    assign bus.rsp_valid  = s2_v_q;
    assign bus.rsp_data   = s2_data_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= UNCFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:   if (bus.cfg_start) state_d = LOAD;
            LOAD:    if (last_beat) state_d = RUN;
            RUN:     if (bus.cfg_start) state_d = DRAIN;
            DRAIN:   if (!s1_v_q && !s2_v_q) state_d = LOAD;
            default: state_d = UNCFG;
        endcase
    end

    // Leaf j covers table bits [16*j +: 16]; the low address nibble picks one bit from each.
    always_comb begin
        leaf_d = '0;
        for (int j = 0; j < LEAVES; j++) begin
            leaf_d[j] = tbl_q[j * 16 + int'(bus.req_addr[3:0])];
        end
    end

    always_comb begin : mux_tree
        logic [LEAVES-1:0] lvl;
        lvl = s1_leaf_q;
        for (int l = 0; l < SEL_W; l++) begin
            for (int k = 0; k < (LEAVES >> (l + 1)); k++) begin
                lvl[k] = s1_sel_q[l] ? lvl[2 * k + 1] : lvl[2 * k];
            end
        end
        tree_out = lvl[0];
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_q      <= '0;
            tbl_q      <= '0;
            cfg_done_q <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_leaf_q  <= '0;
            s1_sel_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_data_q  <= 1'b0;
        end else begin
            cfg_done_q <= last_beat;

            if ((state_q != LOAD) && (state_d == LOAD)) begin
                cnt_q <= '0;
            end else if ((state_q == LOAD) && bus.cfg_start) begin
                cnt_q <= '0;
            end else if (cfg_xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (cfg_xfer) begin
                tbl_q[int'(cnt_q) * CFG_W +: CFG_W] <= bus.cfg_data;
            end

            if (s1_free) begin
                s1_v_q <= req_fire;
                if (req_fire) begin
                    s1_leaf_q <= leaf_d;
                    s1_sel_q  <= bus.req_addr[N-1:4];
                end
            end

            if (s2_free) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_data_q <= tree_out;
                end
            end
        end
    end
endmodule
